uart_link: RTL and testbench
============================

Name: uart_link

Overview:
- Byte-wide 8N1 UART transceiver.
- Sits directly under the sensor request/response state machine:
  - that FSM writes the request byte through `din`/`wr_en`;
  - it consumes received bytes through `dout`/`rdy`/`rdy_clr`.
- Also drives the board TX pin and samples the RX pin.
- One clock domain; RX pin is asynchronous and synchronised internally.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- Derived constants (integer division, truncating):
  - TXDIV = CLK_HZ/BAUD, clocks per transmitted bit.
  - RXDIV = CLK_HZ/(BAUD*16), clocks per 16x oversample tick; minimum 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- din  in  8  byte to transmit.
- wr_en  in  1  transmit request, level-sensitive.
- tx  out  1  serial output, idle high.
- tx_busy  out  1  high while a frame is being shifted out.
- rx  in  1  serial input, asynchronous.
- dout  out  8  last good received byte.
- rdy  out  1  sticky "byte available" flag.
- rdy_clr  in  1  clears rdy.
- frame_err  out  1  one-cycle pulse, stop bit sampled low.
- overrun  out  1  one-cycle pulse, byte completed while rdy already 1.
- parity_err  out  1  one-cycle pulse, parity mismatch (see Optional Feature).

Behaviour:
- Reset (asynchronous, active-high, clock `clock`):
  - tx=1, tx_busy=0, dout=8'h00, rdy=0, frame_err=0, overrun=0, parity_err=0.
  - All counters clear; both FSMs go to IDLE.
  - Reset mid-frame aborts immediately; tx returns high in the same reset assertion.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a rising edge with wr_en=1 and tx_busy=0.
    - din is latched into the shift register.
    - tx_busy=1 and tx=0 from the next cycle.
  - Each of START, DATA, STOP lasts exactly TXDIV clocks.
  - DATA shifts 8 bits LSB first.
  - STOP drives tx=1.
  - After STOP the FSM returns to IDLE and tx_busy=0 on the cycle following the last stop-bit clock.
  - Frame length = 10*TXDIV clocks.
  - wr_en while tx_busy=1 is ignored; no queueing.
  - wr_en held high continuously: the next frame starts on the first cycle tx_busy is 0, giving back-to-back frames with one idle cycle between.
- RX path: rx passes through a 2-flop synchroniser, so the pin-to-FSM latency is 2 clocks.
- Oversample tick: asserted once every RXDIV clocks, free-running.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on the synchronised rx=0; the tick counter restarts.
  - START: at oversample count 8, rx is re-checked.
    - rx=1: false start, return to IDLE, no flags.
    - rx=0: go to DATA.
  - DATA: 8 bits sampled every 16 ticks at mid-bit, LSB first.
  - STOP: sampled 16 ticks after the last data bit.
    - rx=1: dout <= shifted byte and rdy <= 1, both visible on the next clock.
    - rx=0: frame_err pulses for 1 cycle; dout and rdy are unchanged.
  - Return to IDLE right after the stop sample; the next start bit may begin immediately.
- rdy handling:
  - rdy_clr=1 clears rdy on the next edge.
  - A byte completing in the same cycle as rdy_clr: the new byte wins; rdy stays 1 and dout updates.
  - A byte completing while rdy=1 and rdy_clr=0: dout is overwritten, rdy stays 1, overrun pulses 1 cycle.
- TX and RX are fully independent; simultaneous send and receive are allowed (full duplex).

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - Frame becomes 8E1: an even-parity bit follows the data bits on TX, and the TX frame length becomes 11*TXDIV.
  - RX samples the parity bit before STOP.
  - On mismatch: the byte is discarded (dout and rdy unchanged), parity_err pulses 1 cycle, and frame_err is still evaluated.
- Undefined:
  - 8N1 only; parity_err is tied 0.

Test Plan (CLK_HZ=1600000, BAUD=100000 -> TXDIV=16, RXDIV=1):
- Reset: assert reset mid-TX frame -> tx=1 and tx_busy=0 immediately; all outputs at reset values after release.
- TX: din=8'hA5, wr_en pulsed 1 cycle ->
  - tx pattern 0,1,0,1,0,0,1,0,1,1, each held 16 clocks;
  - tx_busy high for exactly 160 clocks;
  - a second wr_en during busy produces no extra frame.
- RX normal: drive 8'h37 on rx -> rdy=1 and dout=8'h37 within 4 clocks of mid stop bit; rdy_clr pulse -> rdy=0 next clock.
- RX errors:
  - 4-clock low glitch on idle rx -> no rdy, no flags.
  - 8'h80 sent with stop bit low -> frame_err single pulse, dout unchanged.
- Overrun/collision:
  - send 8'h11, then 8'h22 without rdy_clr -> overrun pulse, dout=8'h22, rdy=1;
  - rdy_clr asserted on the completion cycle of 8'h33 -> rdy stays 1, dout=8'h33.
- Loopback with tx tied to rx, wr_en held high, din=8'h5A -> repeated rdy with dout=8'h5A.
  - With UART_PARITY_EN: parity bit=0 observed on tx.
  - With UART_PARITY_EN and the injected parity bit flipped -> parity_err pulse, no rdy.

Source files
------------

// File: rtl/uart_link_if.sv
// Purpose: bundles the byte-side and pin-side signals of the uart_link transceiver.
// Latency: none; this is wiring only.
// Backpressure: none; wr_en is level-sensitive and is ignored while tx_busy is high.
interface uart_link_if;
    logic [7:0] din;
    logic       wr_en;
    logic       tx;
    logic       tx_busy;
    logic       rx;
    logic [7:0] dout;
    logic       rdy;
    logic       rdy_clr;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    // Requester side: drives the byte to send, the RX pin and the rdy clear.
    modport master (
        output din, wr_en, rx, rdy_clr,
        input  tx, tx_busy, dout, rdy, frame_err, overrun, parity_err
    );

    // Transceiver side.
    modport slave (
        input  din, wr_en, rx, rdy_clr,
        output tx, tx_busy, dout, rdy, frame_err, overrun, parity_err
    );
endinterface

// File: rtl/uart_link.sv
// Purpose: byte-wide 8N1 UART transceiver (8E1 when UART_PARITY_EN is defined).
// Latency: tx goes low 1 clock after an accepted wr_en; rdy rises about 3 clocks after mid stop bit.
// Backpressure: wr_en is ignored while tx_busy=1 (no queueing); rdy is sticky, and an unread byte is overwritten with an overrun pulse.
module uart_link #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 9600
) (
    input  logic        clock,
    input  logic        reset,
    uart_link_if.slave  link
);
    localparam int TXDIV     = CLK_HZ / BAUD;
    localparam int RXDIV_RAW = CLK_HZ / (BAUD * 16);
    localparam int RXDIV     = (RXDIV_RAW < 1) ? 1 : RXDIV_RAW;
    localparam int TXW       = (TXDIV > 1) ? $clog2(TXDIV) : 1;
    localparam int RXW       = (RXDIV > 1) ? $clog2(RXDIV) : 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    // ---------------- transmitter ----------------
    state_t           r_tx_state;
    state_t           w_tx_next;
    logic [TXW-1:0]   r_tx_cnt;
    logic [2:0]       r_tx_bit;
    logic [7:0]       r_tx_shift;
    logic             w_tx_bit_end;
    logic             w_tx;
    logic             w_tx_busy;
`ifdef UART_PARITY_EN
    logic             r_tx_par;
`endif

    assign w_tx_bit_end = (r_tx_cnt == TXW'(TXDIV - 1));

    // TX state register; reset forces IDLE so tx returns high at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_tx_state <= S_IDLE;
        else       r_tx_state <= w_tx_next;
    end

    // TX next state: every non-idle state lasts one bit period.
    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            S_IDLE:  if (link.wr_en) w_tx_next = S_START;
            S_START: if (w_tx_bit_end) w_tx_next = S_DATA;
            S_DATA:  if (w_tx_bit_end && r_tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                         w_tx_next = S_PAR;
`else
                         w_tx_next = S_STOP;
`endif
                     end
            S_PAR:   if (w_tx_bit_end) w_tx_next = S_STOP;
            S_STOP:  if (w_tx_bit_end) w_tx_next = S_IDLE;
            default: w_tx_next = S_IDLE;
        endcase
    end

    // TX outputs decoded from the registered state and shift register.
    always_comb begin
        w_tx      = 1'b1;
        w_tx_busy = (r_tx_state != S_IDLE);
        case (r_tx_state)
            S_START: w_tx = 1'b0;
            S_DATA:  w_tx = r_tx_shift[0];
`ifdef UART_PARITY_EN
            S_PAR:   w_tx = r_tx_par;
`endif
            default: w_tx = 1'b1;
        endcase
    end

    // TX datapath: bit-period counter, byte latch on accept, LSB-first shift.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'h00;
`ifdef UART_PARITY_EN
            r_tx_par   <= 1'b0;
`endif
        end else begin
            if (r_tx_state == S_IDLE || w_tx_bit_end) r_tx_cnt <= '0;
            else                                      r_tx_cnt <= r_tx_cnt + 1'b1;
            if (r_tx_state == S_IDLE && link.wr_en) begin
                r_tx_shift <= link.din;
                r_tx_bit   <= 3'd0;
`ifdef UART_PARITY_EN
                r_tx_par   <= ^link.din;
`endif
            end else if (r_tx_state == S_DATA && w_tx_bit_end) begin
                r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                r_tx_bit   <= r_tx_bit + 3'd1;
            end
        end
    end

    assign link.tx      = w_tx;
    assign link.tx_busy = w_tx_busy;

    // ---------------- receiver ----------------
    state_t           r_rx_state;
    state_t           w_rx_next;
    logic             r_rx_s1;
    logic             r_rx_s2;
    logic [RXW-1:0]   r_tick_cnt;
    logic             w_tick;
    logic [3:0]       r_os_cnt;
    logic [2:0]       r_rx_bit;
    logic [7:0]       r_rx_shift;
    logic             w_sample;
    logic             w_rx_good;
    logic             w_rx_ferr;
    logic [7:0]       r_dout;
    logic             r_rdy;
    logic             r_frame_err;
    logic             r_overrun;
`ifdef UART_PARITY_EN
    logic             r_rx_par_bad;
    logic             w_rx_perr;
    logic             r_parity_err;
`endif

    assign w_tick   = (r_tick_cnt == RXW'(RXDIV - 1));
    // Start bit is checked half a bit in; every later sample is a full bit later.
    assign w_sample = w_tick && ((r_rx_state == S_START) ? (r_os_cnt == 4'd7) : (r_os_cnt == 4'd15));

    // Two-flop synchroniser for the asynchronous RX pin; idles high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
        end else begin
            r_rx_s1 <= link.rx;
            r_rx_s2 <= r_rx_s1;
        end
    end

    // RX state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_rx_state <= S_IDLE;
        else       r_rx_state <= w_rx_next;
    end

    // RX next state: a high line at the start check is a false start.
    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            S_IDLE:  if (!r_rx_s2) w_rx_next = S_START;
            S_START: if (w_sample) w_rx_next = r_rx_s2 ? S_IDLE : S_DATA;
            S_DATA:  if (w_sample && r_rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                         w_rx_next = S_PAR;
`else
                         w_rx_next = S_STOP;
`endif
                     end
            S_PAR:   if (w_sample) w_rx_next = S_STOP;
            S_STOP:  if (w_sample) w_rx_next = S_IDLE;
            default: w_rx_next = S_IDLE;
        endcase
    end

    // RX outputs: completion strobes at the parity and stop samples.
    always_comb begin
        w_rx_ferr = (r_rx_state == S_STOP) && w_sample && !r_rx_s2;
`ifdef UART_PARITY_EN
        w_rx_good = (r_rx_state == S_STOP) && w_sample && r_rx_s2 && !r_rx_par_bad;
        w_rx_perr = (r_rx_state == S_PAR) && w_sample && (r_rx_s2 != (^r_rx_shift));
`else
        w_rx_good = (r_rx_state == S_STOP) && w_sample && r_rx_s2;
`endif
    end

    // RX datapath: tick divider restarted on start edge, oversample count, shifter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tick_cnt   <= '0;
            r_os_cnt     <= 4'd0;
            r_rx_bit     <= 3'd0;
            r_rx_shift   <= 8'h00;
`ifdef UART_PARITY_EN
            r_rx_par_bad <= 1'b0;
`endif
        end else begin
            if ((r_rx_state == S_IDLE && !r_rx_s2) || w_tick) r_tick_cnt <= '0;
            else                                              r_tick_cnt <= r_tick_cnt + 1'b1;
            if (r_rx_state == S_IDLE || w_sample) r_os_cnt <= 4'd0;
            else if (w_tick)                      r_os_cnt <= r_os_cnt + 4'd1;
            if (r_rx_state == S_IDLE) begin
                r_rx_bit <= 3'd0;
            end else if (r_rx_state == S_DATA && w_sample) begin
                r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 3'd1;
            end
`ifdef UART_PARITY_EN
            if (r_rx_state == S_IDLE)                     r_rx_par_bad <= 1'b0;
            else if (r_rx_state == S_PAR && w_sample)     r_rx_par_bad <= w_rx_perr;
`endif
        end
    end

    // Byte hand-off: a completing byte beats a simultaneous clear; one-cycle error pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dout       <= 8'h00;
            r_rdy        <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef UART_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            if (w_rx_good) begin
                r_dout <= r_rx_shift;
                r_rdy  <= 1'b1;
            end else if (link.rdy_clr) begin
                r_rdy  <= 1'b0;
            end
            r_frame_err  <= w_rx_ferr;
            r_overrun    <= w_rx_good && r_rdy && !link.rdy_clr;
`ifdef UART_PARITY_EN
            r_parity_err <= w_rx_perr;
`endif
        end
    end

    assign link.dout      = r_dout;
    assign link.rdy       = r_rdy;
    assign link.frame_err = r_frame_err;
    assign link.overrun   = r_overrun;
`ifdef UART_PARITY_EN
    assign link.parity_err = r_parity_err;
`else
    assign link.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_link.sv
// Purpose: directed self-checking bench for uart_link at TXDIV=16, RXDIV=1.
// Latency: checks first-bit timing, frame length and rdy latency against hand-computed values.
// Backpressure: exercises ignored wr_en while busy, overrun and rdy_clr collision.
module tb_uart_link;
    localparam int CLK_HZ = 1600000;
    localparam int BAUD   = 100000;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic loop_en = 1'b0;
    logic rx_drive = 1'b1;
`ifdef UART_PARITY_EN
    logic par_flip = 1'b0;
`endif
    int vecs = 0;
    int errs = 0;

    always #5 clock = ~clock;

    uart_link_if link();
    assign link.rx = loop_en ? link.tx : rx_drive;

    uart_link #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clock (clock),
        .reset (reset),
        .link  (link.slave)
    );

    // Pulse and rdy-rise tallies sampled on the falling edge.
    int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, rise_cnt = 0;
    logic rdy_q = 1'b0;
    always @(negedge clock) begin
        if (link.frame_err)  fe_cnt++;
        if (link.overrun)    ov_cnt++;
        if (link.parity_err) pe_cnt++;
        if (link.rdy && !rdy_q) rise_cnt++;
        rdy_q = link.rdy;
    end

    // Drive start, data (and parity) bits, then the stop level; returns 8 clocks into the stop bit.
    task automatic rx_head(input logic [7:0] d, input logic stopv);
        @(posedge clock); #1;
        rx_drive = 1'b0;
        repeat (16) @(posedge clock); #1;
        for (int i = 0; i < 8; i++) begin
            rx_drive = d[i];
            repeat (16) @(posedge clock); #1;
        end
`ifdef UART_PARITY_EN
        rx_drive = (^d) ^ par_flip;
        repeat (16) @(posedge clock); #1;
`endif
        rx_drive = stopv;
        repeat (8) @(posedge clock);
    endtask

    task automatic rx_idle(input int n);
        repeat (8) @(posedge clock); #1;
        rx_drive = 1'b1;
        repeat (n) @(posedge clock); #1;
    endtask

    task automatic test_reset();
        logic [13:0] obs;
        repeat (3) @(negedge clock);
        obs = {link.tx, link.tx_busy, link.dout, link.rdy, link.frame_err, link.overrun, link.parity_err};
        vecs++;
        if (obs !== 14'b1_0_00000000_0_0_0_0) begin
            $display("FAIL reset_state got %b want %b", obs, 14'b1_0_00000000_0_0_0_0);
            errs++;
        end
        @(posedge clock); #1 reset = 1'b0;
        link.din = 8'hA5; link.wr_en = 1'b1;
        @(posedge clock); #1 link.wr_en = 1'b0;
        repeat (40) @(negedge clock);
        vecs++;
        if (link.tx_busy !== 1'b1) begin
            $display("FAIL reset_busy_before got %b want 1", link.tx_busy);
            errs++;
        end
        #2 reset = 1'b1;
        #1;
        vecs++;
        if ({link.tx, link.tx_busy} !== 2'b10) begin
            $display("FAIL reset_midframe got tx=%b busy=%b want tx=1 busy=0", link.tx, link.tx_busy);
            errs++;
        end
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        obs = {link.tx, link.tx_busy, link.dout, link.rdy, link.frame_err, link.overrun, link.parity_err};
        vecs++;
        if (obs !== 14'b1_0_00000000_0_0_0_0) begin
            $display("FAIL reset_release got %b want %b", obs, 14'b1_0_00000000_0_0_0_0);
            errs++;
        end
    endtask

    task automatic test_tx_frame(input logic [7:0] d);
        logic [NB-1:0] expv;
        int busy_cnt;
        logic bad;
        logic extra;
        expv = '1;
        expv[0] = 1'b0;
        expv[8:1] = d;
`ifdef UART_PARITY_EN
        expv[9] = ^d;
`endif
        @(posedge clock); #1;
        link.din = d; link.wr_en = 1'b1;
        @(posedge clock); #1 link.wr_en = 1'b0;
        busy_cnt = 0;
        for (int b = 0; b < NB; b++) begin
            bad = 1'b0;
            for (int k = 0; k < 16; k++) begin
                @(negedge clock);
                if (link.tx !== expv[b]) bad = 1'b1;
                if (link.tx_busy) busy_cnt++;
                if (b == 3 && k == 0) link.wr_en = 1'b1;
                if (b == 3 && k == 1) link.wr_en = 1'b0;
            end
            vecs++;
            if (bad !== 1'b0) begin
                $display("FAIL tx_bit%0d byte %h got tx=%b want %b", b, d, ~expv[b], expv[b]);
                errs++;
            end
        end
        extra = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (link.tx_busy) busy_cnt++;
            if (link.tx !== 1'b1) extra = 1'b1;
        end
        vecs++;
        if (busy_cnt !== NB * 16) begin
            $display("FAIL tx_busy_len got %0d want %0d", busy_cnt, NB * 16);
            errs++;
        end
        vecs++;
        if (extra !== 1'b0) begin
            $display("FAIL tx_no_requeue got extra=%b want 0", extra);
            errs++;
        end
    endtask

    task automatic test_rx_normal();
        int fe0, ov0, pe0;
        logic got;
        fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
        rx_head(8'h37, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (link.rdy) got = 1'b1;
        end
        vecs++;
        if (got !== 1'b1) begin
            $display("FAIL rx_rdy_latency got rdy=%b want 1 within 4 clocks", got);
            errs++;
        end
        vecs++;
        if (link.dout !== 8'h37) begin
            $display("FAIL rx_dout got %h want 37", link.dout);
            errs++;
        end
        rx_idle(10);
        @(negedge clock) link.rdy_clr = 1'b1;
        @(negedge clock) link.rdy_clr = 1'b0;
        vecs++;
        if (link.rdy !== 1'b0) begin
            $display("FAIL rx_rdy_clr got %b want 0", link.rdy);
            errs++;
        end
        vecs++;
        if ((fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0) !== 0) begin
            $display("FAIL rx_normal_flags got %0d pulses want 0", (fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0));
            errs++;
        end
    endtask

    task automatic test_rx_errors();
        int fe0, ov0, pe0, r0;
        fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt; r0 = rise_cnt;
        @(posedge clock); #1 rx_drive = 1'b0;
        repeat (4) @(posedge clock); #1 rx_drive = 1'b1;
        repeat (40) @(posedge clock);
        vecs++;
        if ((rise_cnt - r0) + (fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0) !== 0) begin
            $display("FAIL rx_glitch got %0d events want 0", (rise_cnt - r0) + (fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0));
            errs++;
        end
        fe0 = fe_cnt;
        rx_head(8'h80, 1'b0);
        rx_idle(40);
        vecs++;
        if (fe_cnt - fe0 !== 1) begin
            $display("FAIL rx_frame_err got %0d pulse cycles want 1", fe_cnt - fe0);
            errs++;
        end
        vecs++;
        if ({link.dout, link.rdy} !== {8'h37, 1'b0}) begin
            $display("FAIL rx_ferr_hold got dout=%h rdy=%b want dout=37 rdy=0", link.dout, link.rdy);
            errs++;
        end
    endtask

    task automatic test_overrun();
        int ov0;
        ov0 = ov_cnt;
        rx_head(8'h11, 1'b1);
        rx_idle(10);
        vecs++;
        if ({link.dout, link.rdy} !== {8'h11, 1'b1} || ov_cnt != ov0) begin
            $display("FAIL ovr_first got dout=%h rdy=%b ov=%0d want dout=11 rdy=1 ov=0", link.dout, link.rdy, ov_cnt - ov0);
            errs++;
        end
        rx_head(8'h22, 1'b1);
        rx_idle(10);
        vecs++;
        if (ov_cnt - ov0 !== 1) begin
            $display("FAIL ovr_pulse got %0d want 1", ov_cnt - ov0);
            errs++;
        end
        vecs++;
        if ({link.dout, link.rdy} !== {8'h22, 1'b1}) begin
            $display("FAIL ovr_data got dout=%h rdy=%b want dout=22 rdy=1", link.dout, link.rdy);
            errs++;
        end
    endtask

    task automatic test_collision();
        int ov0;
        ov0 = ov_cnt;
        rx_head(8'h33, 1'b1);
        @(negedge clock);
        @(negedge clock);
        @(negedge clock) link.rdy_clr = 1'b1;
        @(negedge clock) link.rdy_clr = 1'b0;
        vecs++;
        if ({link.dout, link.rdy} !== {8'h33, 1'b1}) begin
            $display("FAIL coll_new_wins got dout=%h rdy=%b want dout=33 rdy=1", link.dout, link.rdy);
            errs++;
        end
        @(negedge clock);
        vecs++;
        if (link.rdy !== 1'b1 || ov_cnt != ov0) begin
            $display("FAIL coll_hold got rdy=%b ov=%0d want rdy=1 ov=0", link.rdy, ov_cnt - ov0);
            errs++;
        end
        rx_idle(10);
        @(negedge clock) link.rdy_clr = 1'b1;
        @(negedge clock) link.rdy_clr = 1'b0;
    endtask

    task automatic test_loopback();
        int got, bad, ov0, t;
        ov0 = ov_cnt;
        got = 0; bad = 0;
        @(negedge clock);
        loop_en = 1'b1; link.din = 8'h5A; link.wr_en = 1'b1;
        for (int i = 0; i < 700; i++) begin
            @(negedge clock);
            link.rdy_clr = 1'b0;
            if (link.rdy) begin
                if (link.dout !== 8'h5A) bad++;
                got++;
                link.rdy_clr = 1'b1;
            end
        end
        link.rdy_clr = 1'b0;
        link.wr_en = 1'b0;
        vecs++;
        if (got < 3) begin
            $display("FAIL loop_count got %0d bytes want at least 3", got);
            errs++;
        end
        vecs++;
        if (bad !== 0 || ov_cnt != ov0) begin
            $display("FAIL loop_data got %0d bad bytes %0d overruns want 0", bad, ov_cnt - ov0);
            errs++;
        end
        t = 0;
        while (link.tx_busy && t < 400) begin
            @(negedge clock);
            t++;
        end
        vecs++;
        if (link.tx_busy !== 1'b0) begin
            $display("FAIL loop_drain got busy=%b want 0 within 400 clocks", link.tx_busy);
            errs++;
        end
        repeat (40) @(negedge clock);
        loop_en = 1'b0;
        link.rdy_clr = 1'b1;
        @(negedge clock) link.rdy_clr = 1'b0;
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity_err();
        int pe0, r0, fe0;
        pe0 = pe_cnt; r0 = rise_cnt; fe0 = fe_cnt;
        par_flip = 1'b1;
        rx_head(8'h5A, 1'b1);
        rx_idle(20);
        par_flip = 1'b0;
        vecs++;
        if (pe_cnt - pe0 !== 1) begin
            $display("FAIL par_err_pulse got %0d want 1", pe_cnt - pe0);
            errs++;
        end
        vecs++;
        if ((rise_cnt - r0) !== 0 || link.rdy !== 1'b0 || (fe_cnt - fe0) !== 0) begin
            $display("FAIL par_discard got rises=%0d rdy=%b fe=%0d want 0 0 0", rise_cnt - r0, link.rdy, fe_cnt - fe0);
            errs++;
        end
    endtask
`endif

    initial begin
        link.din = 8'h00;
        link.wr_en = 1'b0;
        link.rdy_clr = 1'b0;
        test_reset();
        test_tx_frame(8'hA5);
`ifdef UART_PARITY_EN
        test_tx_frame(8'h5A);
`endif
        test_rx_normal();
        test_rx_errors();
        test_overrun();
        test_collision();
        test_loopback();
`ifdef UART_PARITY_EN
        test_parity_err();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
